// File: rtl/pipe_stage_elastic_if.sv
// rtl/pipe_stage_elastic_if.sv - handshake bundle for the elastic pipeline stage
interface pipe_stage_elastic_if #(
    parameter int DATA_W = 48
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;

    // Driven by the surrounding pipeline (upstream producer, downstream consumer, flush source)
    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    // Driven by the stage itself
    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );
endinterface

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - generic-width valid/ready pipeline stage with optional skid entry and flush
module pipe_stage_elastic #(
    parameter int DATA_W = 48,
    parameter int SKID   = 1
) (
    input  logic                clock,
    input  logic                reset,
    pipe_stage_elastic_if.slave bus
);
    // EMPTY: nothing held; ONE: main holds the head; FULL: main + skid both hold data
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] skid_data;
    logic              main_valid;
    logic              skid_valid;
    logic              in_fire;
    logic              out_fire;

    assign main_valid = (state != ST_EMPTY);
    assign skid_valid = (state == ST_FULL);

    // With a skid entry, in_ready is a pure function of registered state, so it never
    // combinationally depends on out_ready; without it, a full stage can still accept
    // when the downstream drains it in the same cycle.
    if (SKID != 0) begin : g_skid
        assign bus.in_ready = ~skid_valid;
    end else begin : g_noskid
        assign bus.in_ready = ~main_valid | bus.out_ready;
    end

    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = main_valid & bus.out_ready;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Occupancy state and data movement; flush drops every held entry and the same-cycle input
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_EMPTY;
            main_data <= '0;
            skid_data <= '0;
        end else if (bus.flush) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_data <= bus.in_data;
                        state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_data <= bus.in_data;
                    end else if (in_fire) begin
                        // Only reachable with a skid entry: new data parks behind the head
                        skid_data <= bus.in_data;
                        state     <= ST_FULL;
                    end else if (out_fire) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_data <= skid_data;
                        state     <= ST_ONE;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - self-checking bench for both stage variants against a FIFO model
module tb_pipe_stage_elastic;
    localparam int DW = 48;
    localparam logic [DW-1:0] VA = 48'h000100010002;
    localparam logic [DW-1:0] VB = 48'h000200020003;
    localparam logic [DW-1:0] VC = 48'h0003000300AA;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    int total;
    int bad;

    // Reference model: a FIFO of capacity 2 (skid) or 1 (no skid), per instance
    int            cnt  [2];
    logic [DW-1:0] mbuf [2][2];

    pipe_stage_elastic_if #(.DATA_W(DW)) bus1 ();
    pipe_stage_elastic_if #(.DATA_W(DW)) bus0 ();

    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.flush     = flush;
    assign bus1.out_ready = out_ready;
    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.flush     = flush;
    assign bus0.out_ready = out_ready;

    pipe_stage_elastic #(.DATA_W(DW), .SKID(1)) u_skid (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    pipe_stage_elastic #(.DATA_W(DW), .SKID(0)) u_noskid (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready(input int s);
        if (s != 0) return cnt[s] < 2;
        return (cnt[s] == 0) || out_ready;
    endfunction

    task automatic cmp_dut(input int s);
        logic          ov;
        logic [DW-1:0] od;
        logic [1:0]    occ;
        logic          ir;
        if (s != 0) begin
            ov = bus1.out_valid; od = bus1.out_data; occ = bus1.occupancy; ir = bus1.in_ready;
        end else begin
            ov = bus0.out_valid; od = bus0.out_data; occ = bus0.occupancy; ir = bus0.in_ready;
        end
        check($sformatf("s%0d_out_valid", s), 64'(ov), 64'(cnt[s] > 0));
        check($sformatf("s%0d_occupancy", s), 64'(occ), 64'(cnt[s]));
        check($sformatf("s%0d_in_ready", s), 64'(ir), 64'(exp_ready(s)));
        if (cnt[s] > 0) check($sformatf("s%0d_out_data", s), 64'(od), 64'(mbuf[s][0]));
    endtask

    // One clock: compare both instances to the model, advance the model, then verify stall hold
    task automatic tick;
        bit            inf [2];
        bit            outf[2];
        bit            stl [2];
        logic [DW-1:0] pd  [2];
        #1;
        for (int s = 0; s < 2; s++) begin
            cmp_dut(s);
            inf[s]  = in_valid && exp_ready(s);
            outf[s] = (cnt[s] > 0) && out_ready;
            stl[s]  = (cnt[s] > 0) && !out_ready && !flush;
            pd[s]   = mbuf[s][0];
        end
        @(posedge clock);
        for (int s = 0; s < 2; s++) begin
            if (flush) begin
                cnt[s] = 0;
            end else begin
                if (outf[s]) begin
                    mbuf[s][0] = mbuf[s][1];
                    cnt[s]--;
                end
                if (inf[s]) begin
                    mbuf[s][cnt[s]] = in_data;
                    cnt[s]++;
                end
            end
        end
        #1;
        for (int s = 0; s < 2; s++) begin
            if (stl[s]) begin
                check($sformatf("s%0d_hold_valid", s),
                      64'(s != 0 ? bus1.out_valid : bus0.out_valid), 64'd1);
                check($sformatf("s%0d_hold_data", s),
                      64'(s != 0 ? bus1.out_data : bus0.out_data), 64'(pd[s]));
            end
        end
    endtask

    initial begin
        logic [63:0] rnd;
        total     = 0;
        bad       = 0;
        cnt[0]    = 0;
        cnt[1]    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rst_out_valid1", 64'(bus1.out_valid), 64'd0);
        check("rst_occ1",       64'(bus1.occupancy), 64'd0);
        check("rst_in_ready1",  64'(bus1.in_ready),  64'd1);
        check("rst_out_data1",  64'(bus1.out_data),  64'd0);
        check("rst_in_ready0",  64'(bus0.in_ready),  64'd1);
        check("rst_out_data0",  64'(bus0.out_data),  64'd0);

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_data = DW'(k);
            tick();
            check("stream_data1", 64'(bus1.out_data), 64'(k));
            check("stream_rdy1",  64'(bus1.in_ready), 64'd1);
            check("stream_occ1",  64'(bus1.occupancy), 64'd1);
            check("stream_data0", 64'(bus0.out_data), 64'(k));
        end
        in_valid = 1'b0;
        tick();

        // Backpressure into the skid entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VA;
        tick();
        in_data = VB;
        tick();
        in_valid = 1'b0;
        check("bp_occ",   64'(bus1.occupancy), 64'd2);
        check("bp_ready", 64'(bus1.in_ready),  64'd0);
        check("bp_dataA", 64'(bus1.out_data),  64'(VA));
        tick();
        check("bp_holdA", 64'(bus1.out_data),  64'(VA));
        out_ready = 1'b1;
        tick();
        check("bp_dataB",   64'(bus1.out_data), 64'(VB));
        check("bp_ready_up", 64'(bus1.in_ready), 64'd1);
        tick();
        check("bp_drained", 64'(bus1.out_valid), 64'd0);

        // Flush while FULL with C offered in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VA;
        tick();
        in_data = VB;
        tick();
        in_data = VC;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 64'(bus1.out_valid), 64'd0);
        check("fl_occ",       64'(bus1.occupancy), 64'd0);
        check("fl_ready",     64'(bus1.in_ready),  64'd1);
        check("fl_out_valid0", 64'(bus0.out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("fl_no_c", 64'(bus1.out_valid), 64'd0);

        // Single-entry stall, then release in the cycle B is offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VA;
        tick();
        in_data = VB;
        #1;
        check("s0_stall_ready", 64'(bus0.in_ready), 64'd0);
        check("s0_stall_dataA", 64'(bus0.out_data), 64'(VA));
        out_ready = 1'b1;
        #1;
        check("s0_release_ready", 64'(bus0.in_ready), 64'd1);
        tick();
        check("s0_dataB",  64'(bus0.out_data),  64'(VB));
        check("s0_validB", 64'(bus0.out_valid), 64'd1);
        in_valid = 1'b0;
        tick();

        // Asynchronous reset with the skid stage FULL
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VA;
        tick();
        in_data = VB;
        tick();
        in_valid = 1'b0;
        check("rm_full", 64'(bus1.occupancy), 64'd2);
        #1 reset = 1'b1;
        #1;
        check("rm_out_valid1", 64'(bus1.out_valid), 64'd0);
        check("rm_occ1",       64'(bus1.occupancy), 64'd0);
        check("rm_out_valid0", 64'(bus0.out_valid), 64'd0);
        cnt[0] = 0;
        cnt[1] = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("rm_ready1", 64'(bus1.in_ready), 64'd1);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rnd       = {$urandom, $urandom};
            in_data   = rnd[DW-1:0];
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 19) == 0);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
